// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage: single-cycle mult/mt*, restoring
// divider (one quotient bit per cycle), owns the HI/LO registers.
module mdu_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              stallreq,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_rdata,
    output logic [DATA_W-1:0] lo_rdata
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic              neg_q;
    logic              neg_r;

    logic                div_op;
    logic                b_zero;
    logic                signed_div;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;

    logic [DATA_W:0]     trial_sh;
    logic [DATA_W:0]     trial_diff;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   quo_nxt;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   quo_fix;

    assign div_op     = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign b_zero     = (src_b == '0);
    assign signed_div = (op_code == OP_DIV);
    assign a_neg      = signed_div && src_a[DATA_W-1];
    assign b_neg      = signed_div && src_b[DATA_W-1];
    assign a_abs      = a_neg ? -src_a : src_a;
    assign b_abs      = b_neg ? -src_b : src_b;

    // Operands widened to the full product width so the multiply is exact.
    assign prod_s = {{DATA_W{src_a[DATA_W-1]}}, src_a} * {{DATA_W{src_b[DATA_W-1]}}, src_b};
    assign prod_u = {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};

    // One restoring step: the remainder stays below the divisor, so the
    // top bit of the (DATA_W+1)-bit difference is the borrow.
    always_comb begin
        trial_sh   = {rem, quo[DATA_W-1]};
        trial_diff = trial_sh - {1'b0, dvsr};
        q_bit      = ~trial_diff[DATA_W];
        rem_nxt    = q_bit ? trial_diff[DATA_W-1:0] : trial_sh[DATA_W-1:0];
        quo_nxt    = {quo[DATA_W-2:0], q_bit};
        quo_fix    = neg_q ? -quo_nxt : quo_nxt;
        rem_fix    = neg_r ? -rem_nxt : rem_nxt;
    end

    assign stallreq = (state == DIV) ||
                      ((state == IDLE) && op_valid && !flush && div_op && !b_zero);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign hi_rdata = hi;
    assign lo_rdata = lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (op_code)
                            OP_MULT:  {hi, lo} <= prod_s;
                            OP_MULTU: {hi, lo} <= prod_u;
                            OP_MTHI:  hi <= src_a;
                            OP_MTLO:  lo <= src_a;
                            OP_DIV, OP_DIVU: begin
                                if (!b_zero) begin
                                    rem   <= '0;
                                    quo   <= a_abs;
                                    dvsr  <= b_abs;
                                    neg_q <= a_neg ^ b_neg;
                                    neg_r <= a_neg;
                                    cnt   <= '0;
                                    state <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
                        hi    <= rem_fix;
                        lo    <= quo_fix;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: mult/multu, mthi/mtlo, signed/unsigned divide,
// divide by zero, flush mid-divide and same-cycle flush suppression.
module tb_mdu_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         op_valid;
    logic [2:0]   op_code;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         stallreq;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_rdata;
    logic [W-1:0] lo_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.DATA_W(W), .DIV_CYCLES(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .op_valid (op_valid),
        .op_code  (op_code),
        .src_a    (src_a),
        .src_b    (src_b),
        .stallreq (stallreq),
        .busy     (busy),
        .done     (done),
        .hi_rdata (hi_rdata),
        .lo_rdata (lo_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single-cycle op presented for one cycle; sampled just before the edge.
    task automatic one_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic fl, output logic stall_seen);
        @(negedge clk);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b; flush = fl;
        #1 stall_seen = stallreq;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
    endtask

    // Full divide with the op held until DONE; operands scrambled after accept.
    task automatic run_div(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input int exp_stalls);
        int  stalls;
        bit  seen_done;
        stalls = 0;
        seen_done = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stallreq) stalls++;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
            src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
        end
        check({tag, "_done"}, 64'(seen_done), 64'd1);
        check({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi_rdata), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo_rdata), 64'(exp_lo));
    endtask

    initial begin
        logic st;
        rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_code = '0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_hi", 64'(hi_rdata), 64'd0);
        check("rst_lo", 64'(lo_rdata), 64'd0);
        check("rst_stall", 64'(stallreq), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        one_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, st);
        check("mult_stall", 64'(st), 64'd0);
        check("mult_hilo", {hi_rdata, lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFE);
        one_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, st);
        check("multu_stall", 64'(st), 64'd0);
        check("multu_hilo", {hi_rdata, lo_rdata}, 64'h0000_0001_FFFF_FFFE);
        one_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, st);
        check("multu2_hilo", {hi_rdata, lo_rdata}, 64'h0B00_EA4E_242D_2080);

        run_div("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_div("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_div("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        run_div("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_div("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 33);

        one_op(3'd4, 32'h55, 32'd0, 1'b0, st);
        one_op(3'd5, 32'hAA, 32'd0, 1'b0, st);
        check("mt_hilo", {hi_rdata, lo_rdata}, {32'h55, 32'hAA});
        one_op(3'd2, 32'd123, 32'd0, 1'b0, st);
        check("div0_stall", 64'(st), 64'd0);
        check("div0_busy", 64'(busy), 64'd0);
        check("div0_hilo", {hi_rdata, lo_rdata}, {32'h55, 32'hAA});

        one_op(3'd0, 32'd3, 32'd5, 1'b1, st);
        check("flush_mult_hilo", {hi_rdata, lo_rdata}, {32'h55, 32'hAA});
        one_op(3'd3, 32'd9, 32'd2, 1'b1, st);
        check("flush_div_stall", 64'(st), 64'd0);
        check("flush_div_busy", 64'(busy), 64'd0);
        one_op(3'd6, 32'd1, 32'd1, 1'b0, st);
        check("op6_hilo", {hi_rdata, lo_rdata}, {32'h55, 32'hAA});

        // Flush during the 10th DIV cycle.
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd3; src_a = 32'd1000; src_b = 32'd33;
        repeat (10) @(negedge clk);
        #1 check("midflush_busy_pre", 64'(busy), 64'd1);
        flush = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("midflush_busy", 64'(busy), 64'd0);
        check("midflush_stall", 64'(stallreq), 64'd0);
        check("midflush_hilo", {hi_rdata, lo_rdata}, {32'h55, 32'hAA});
        run_div("divu_after_flush", 3'd3, 32'd1000, 32'd33, 32'd10, 32'd30, 33);

        // Reset in the middle of a divide discards it.
        @(negedge clk);
        op_valid = 1'b1; op_code = 3'd3; src_a = 32'd50; src_b = 32'd5;
        repeat (5) @(negedge clk);
        rst = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hilo", {hi_rdata, lo_rdata}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
